// File: rtl/coverfloat_vector_packer_pkg.sv
// Shared cover-vector definitions: record layout, field offsets and the record sanity check.
// Receivers unpack beats with the same cover_vec_t.
package coverfloat_vector_packer_pkg;

    localparam int unsigned COVER_VECTOR_WIDTH = 804;

    // Field LSB positions inside the 804-bit record (bit 803 is the MSB of op).
    localparam int unsigned CV_PAD_LSB     = 0;
    localparam int unsigned CV_FLAGS_LSB   = 3;
    localparam int unsigned CV_INT_M_LSB   = 11;
    localparam int unsigned CV_INT_X_LSB   = 203;
    localparam int unsigned CV_INT_S_LSB   = 235;
    localparam int unsigned CV_RES_FMT_LSB = 236;
    localparam int unsigned CV_RES_LSB     = 244;
    localparam int unsigned CV_OP_FMT_LSB  = 372;
    localparam int unsigned CV_C_LSB       = 380;
    localparam int unsigned CV_B_LSB       = 508;
    localparam int unsigned CV_A_LSB       = 636;
    localparam int unsigned CV_RM_LSB      = 764;
    localparam int unsigned CV_OP_LSB      = 772;

    localparam logic [7:0] ROUND_NEAR_EVEN   = 8'd0;
    localparam logic [7:0] ROUND_MIN_MAG     = 8'd1;
    localparam logic [7:0] ROUND_MIN         = 8'd2;
    localparam logic [7:0] ROUND_MAX         = 8'd3;
    localparam logic [7:0] ROUND_NEAR_MAXMAG = 8'd4;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } packer_state_e;

    typedef struct packed {
        logic [31:0]  op;
        logic [7:0]   rm;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [7:0]   op_fmt;
        logic [127:0] res;
        logic [7:0]   res_fmt;
        logic         int_s;
        logic [31:0]  int_x;
        logic [191:0] int_m;
        logic [7:0]   flags;
        logic [2:0]   pad;
    } cover_vec_t;

    function automatic logic is_valid_record(input logic [31:0] op, input logic [7:0] rm);
        return (op[31:4] != 28'd0) && (rm <= ROUND_NEAR_MAXMAG);
    endfunction

endpackage

// File: rtl/coverfloat_vector_packer_if.sv
// Record-in / beat-out bus of the cover-vector packer, plus its statistics counters.
// master = record producer and beat sink side; slave = the packer.
interface coverfloat_vector_packer_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_op;
    logic [7:0]        in_rm;
    logic [127:0]      in_a;
    logic [127:0]      in_b;
    logic [127:0]      in_c;
    logic [7:0]        in_op_fmt;
    logic [127:0]      in_res;
    logic [7:0]        in_res_fmt;
    logic              in_int_s;
    logic [31:0]       in_int_x;
    logic [191:0]      in_int_m;
    logic [7:0]        in_flags;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic [CNT_W-1:0]  rec_count;
    logic [CNT_W-1:0]  drop_count;

    modport master (
        output in_valid, in_op, in_rm, in_a, in_b, in_c, in_op_fmt, in_res, in_res_fmt,
               in_int_s, in_int_x, in_int_m, in_flags, out_ready,
        input  in_ready, out_valid, out_data, out_last, rec_count, drop_count
    );

    modport slave (
        input  in_valid, in_op, in_rm, in_a, in_b, in_c, in_op_fmt, in_res, in_res_fmt,
               in_int_s, in_int_x, in_int_m, in_flags, out_ready,
        output in_ready, out_valid, out_data, out_last, rec_count, drop_count
    );
endinterface

// File: rtl/coverfloat_word_serializer.sv
// Generic frame shifter: emits a loaded frame MSB-word-first as NWORDS valid/ready beats.
// A load takes priority over a shift, so a new frame can replace the one finishing this cycle.
module coverfloat_word_serializer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned NWORDS = 26
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic [WORD_W*NWORDS-1:0] i_frame,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [WORD_W-1:0]        o_data,
    output logic                     o_last,
    output logic                     o_done
);
    localparam int unsigned FRAME_W = WORD_W * NWORDS;
    localparam int unsigned IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [FRAME_W-1:0] r_frame;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;
    logic               w_fire;
    logic               w_last;

    assign w_last = r_valid && (r_idx == IDX_W'(NWORDS - 1));
    assign w_fire = r_valid && i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_frame <= i_frame;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_frame <= r_frame << WORD_W;
            if (w_last) begin
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_valid ? r_frame[FRAME_W-1 -: WORD_W] : '0;
    assign o_last  = w_last;
    assign o_done  = w_fire && w_last;
endmodule

// File: rtl/coverfloat_vector_packer.sv
// Packs one retired FP operation into an 804-bit cover vector and streams it as WORD_W beats.
// Records failing the op/rounding-mode sanity check are dropped and counted instead.
module coverfloat_vector_packer
    import coverfloat_vector_packer_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input logic                        clk,
    input logic                        reset,
    coverfloat_vector_packer_if.slave  bus
);
    localparam int unsigned NWORDS  = (COVER_VECTOR_WIDTH + WORD_W - 1) / WORD_W;
    localparam int unsigned FRAME_W = NWORDS * WORD_W;

    packer_state_e      r_state;
    packer_state_e      w_state_d;
    cover_vec_t         w_rec;
    logic [FRAME_W-1:0] w_frame;
    logic               w_ok;
    logic               w_in_ready;
    logic               w_load;
    logic               w_drop;
    logic               w_ser_last;
    logic               w_ser_done;
    logic [CNT_W-1:0]   r_rec_count;
    logic [CNT_W-1:0]   r_drop_count;

    always_comb begin
        w_rec         = '0;
        w_rec.op      = bus.in_op;
        w_rec.rm      = bus.in_rm;
        w_rec.a       = bus.in_a;
        w_rec.b       = bus.in_b;
        w_rec.c       = bus.in_c;
        w_rec.op_fmt  = bus.in_op_fmt;
        w_rec.res     = bus.in_res;
        w_rec.res_fmt = bus.in_res_fmt;
        w_rec.int_s   = bus.in_int_s;
        w_rec.int_x   = bus.in_int_x;
        w_rec.int_m   = bus.in_int_m;
        w_rec.flags   = bus.in_flags;
        // Left-align the record in the frame; the low pad stays zero.
        w_frame                                = '0;
        w_frame[FRAME_W-1 -: COVER_VECTOR_WIDTH] = w_rec;
    end

    assign w_ok = is_valid_record(bus.in_op, bus.in_rm);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_in_ready = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_ok) begin
                    w_state_d = StSend;
                end
            end
            StSend: begin
                // Only open for a new record while the final beat is being taken.
                w_in_ready = w_ser_last && bus.out_ready;
                if (w_in_ready) begin
                    w_state_d = (bus.in_valid && w_ok) ? StSend : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_load = bus.in_valid && w_in_ready && w_ok;
    assign w_drop = bus.in_valid && w_in_ready && !w_ok;

    coverfloat_word_serializer #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_frame (w_frame),
        .i_ready (bus.out_ready),
        .o_valid (bus.out_valid),
        .o_data  (bus.out_data),
        .o_last  (w_ser_last),
        .o_done  (w_ser_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_ser_done && (r_rec_count != '1)) begin
                r_rec_count <= r_rec_count + CNT_W'(1);
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_last   = w_ser_last;
    assign bus.rec_count  = r_rec_count;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_coverfloat_vector_packer.sv
// Directed-vector bench for coverfloat_vector_packer (WORD_W=32, 26 beats per record).
// Expected frames come from a plain field concatenation of each stimulus record.
module tb_coverfloat_vector_packer;

    localparam int unsigned NW = 26;

    typedef struct {
        logic [31:0]  op;
        logic [7:0]   rm;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [7:0]   op_fmt;
        logic [127:0] res;
        logic [7:0]   res_fmt;
        logic         int_s;
        logic [31:0]  int_x;
        logic [191:0] int_m;
        logic [7:0]   flags;
        logic         exp_drop;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    coverfloat_vector_packer_if #(.WORD_W(32), .CNT_W(32)) bus ();

    coverfloat_vector_packer #(.WORD_W(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          exp_rec = 0;
    int          exp_drop = 0;
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic        s_valid, s_last, s_acc, s_in_ready;
    logic [31:0] s_data, s_rec, s_drop;
    vec_t        tbl[8];
    vec_t        fadd;

    task automatic check(input string name, input logic [831:0] act, input logic [831:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] op, input logic [7:0] rm,
                                input logic [127:0] a, input logic [127:0] b,
                                input logic [127:0] c, input logic [7:0] op_fmt,
                                input logic [127:0] res, input logic [7:0] res_fmt,
                                input logic int_s, input logic [31:0] int_x,
                                input logic [191:0] int_m, input logic [7:0] flags,
                                input logic exp_drop);
        vec_t v;
        v.op = op; v.rm = rm; v.a = a; v.b = b; v.c = c; v.op_fmt = op_fmt;
        v.res = res; v.res_fmt = res_fmt; v.int_s = int_s; v.int_x = int_x;
        v.int_m = int_m; v.flags = flags; v.exp_drop = exp_drop;
        return v;
    endfunction

    function automatic logic [831:0] ref_frame(input vec_t v);
        return {v.op, v.rm, v.a, v.b, v.c, v.op_fmt, v.res, v.res_fmt, v.int_s, v.int_x,
                v.int_m, v.flags, 3'b000, 28'd0};
    endfunction

    function automatic logic [831:0] q_frame(input int off);
        logic [831:0] f = '0;
        for (int i = 0; i < NW; i++) f[831-32*i -: 32] = q_data[off+i];
        return f;
    endfunction

    function automatic logic [25:0] q_lasts(input int off);
        logic [25:0] m = '0;
        for (int i = 0; i < NW; i++) m[i] = q_last[off+i];
        return m;
    endfunction

    task automatic set_rec(input vec_t v);
        bus.in_op = v.op; bus.in_rm = v.rm; bus.in_a = v.a; bus.in_b = v.b; bus.in_c = v.c;
        bus.in_op_fmt = v.op_fmt; bus.in_res = v.res; bus.in_res_fmt = v.res_fmt;
        bus.in_int_s = v.int_s; bus.in_int_x = v.int_x; bus.in_int_m = v.int_m;
        bus.in_flags = v.flags;
    endtask

    // Called just after a falling edge: sample, log any beat handshake, advance one cycle.
    task automatic step();
        #1;
        s_valid    = bus.out_valid;
        s_data     = bus.out_data;
        s_last     = bus.out_last;
        s_in_ready = bus.in_ready;
        s_acc      = bus.in_valid && bus.in_ready;
        s_rec      = bus.rec_count;
        s_drop     = bus.drop_count;
        if (bus.out_valid && bus.out_ready) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send(input vec_t v, input string name);
        int k = 0;
        set_rec(v);
        bus.in_valid = 1'b1;
        s_acc = 1'b0;
        while (!s_acc && k < 100) begin
            step();
            k++;
        end
        bus.in_valid = 1'b0;
        check({name, " accept"}, 832'(s_acc), 832'(1));
    endtask

    task automatic collect(input int n, input int budget, input bit rnd);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            k++;
        end
    endtask

    task automatic run_record(input vec_t v, input string name, input bit rnd);
        clear_q();
        send(v, name);
        collect(NW, 600, rnd);
        check({name, " beats"}, 832'(q_data.size()), 832'(NW));
        if (q_data.size() == NW) begin
            check({name, " frame"}, q_frame(0), ref_frame(v));
            check({name, " last"}, 832'(q_lasts(0)), 832'(26'h2000000));
        end
        exp_rec++;
        bus.out_ready = 1'b1;
        step();
        check({name, " rec_count"}, 832'(s_rec), 832'(exp_rec));
    endtask

    initial begin
        vec_t v;
        logic [831:0] fr;
        int k;

        fadd = mk(32'h10, 8'd0, 128'h3F800000, 128'h40000000, '0, 8'h00, 128'h40400000, 8'h00,
                  1'b0, 32'h0, '0, 8'h00, 1'b0);
        tbl[0] = fadd;
        tbl[1] = mk(32'h5, 8'd0, 128'h1, 128'h2, '0, 8'h0, 128'h3, 8'h0, 1'b0, '0, '0, 8'h0,
                    1'b1);
        tbl[2] = mk(32'h10, 8'd7, 128'h1, 128'h2, '0, 8'h0, 128'h3, 8'h0, 1'b0, '0, '0, 8'h0,
                    1'b1);
        tbl[3] = mk(32'h21, 8'd4, 128'h0123456789abcdef_fedcba9876543210,
                    128'hdeadbeef_cafef00d_12345678_9abcdef0, 128'h55aa55aa_0f0f0f0f_33cc33cc_f00dface,
                    8'h02, 128'h00000000_00000000_c0ffee00_11223344, 8'h03, 1'b1, 32'hFFFFFFFB,
                    192'ha5a5a5a5_5a5a5a5a_01234567_89abcdef_0badc0de_feedbeef, 8'h1F, 1'b0);
        tbl[4] = mk(32'hFFFFFFFF, 8'd5, '1, '1, '1, 8'hFF, '1, 8'hFF, 1'b1, '1, '1, 8'hFF, 1'b1);
        tbl[5] = mk(32'h0000000F, 8'd0, 128'h7, '0, '0, 8'h0, '0, 8'h0, 1'b0, '0, '0, 8'h0, 1'b1);
        tbl[6] = mk(32'h80000000, 8'd3, '1, '1, '1, 8'hFF, '1, 8'hFF, 1'b1, '1, '1, 8'hFF, 1'b0);
        tbl[7] = mk(32'h10, 8'hFF, 128'h9, '0, '0, 8'h0, '0, 8'h0, 1'b0, '0, '0, 8'h0, 1'b1);

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_rec(fadd);
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;   // ready with nothing valid must be harmless
        step();
        check("rst in_ready", 832'(s_in_ready), 832'(1));
        check("rst out_valid", 832'(s_valid), 832'(0));
        check("rst out_last", 832'(s_last), 832'(0));
        check("rst out_data", 832'(s_data), 832'(0));
        check("rst rec_count", 832'(s_rec), 832'(0));
        check("rst drop_count", 832'(s_drop), 832'(0));

        // FADD with hand-derived beat values.
        run_record(fadd, "fadd", 1'b0);
        if (q_data.size() == NW) begin
            check("fadd beat0", 832'(q_data[0]), 832'(32'h00000010));
            check("fadd beat1 rm", 832'(q_data[1][31:24]), 832'(8'h00));
            check("fadd beat4 a", 832'(q_data[4]), 832'(32'h003F8000));
            check("fadd beat8 b", 832'(q_data[8]), 832'(32'h00400000));
            check("fadd beat16 res", 832'(q_data[16]), 832'(32'h00004040));
            check("fadd beat25 pad", 832'(q_data[25][27:0]), 832'(28'd0));
        end

        // Stall on beat 3 for 5 cycles.
        clear_q();
        bus.out_ready = 1'b1;
        send(fadd, "stall");
        collect(3, 50, 1'b0);
        fr = ref_frame(fadd);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall%0d valid", i), 832'(s_valid), 832'(1));
            check($sformatf("stall%0d data", i), 832'(s_data), 832'(fr[831-96 -: 32]));
        end
        collect(NW, 100, 1'b0);
        check("stall beats", 832'(q_data.size()), 832'(NW));
        if (q_data.size() == NW) check("stall frame", q_frame(0), fr);
        exp_rec++;
        step();
        check("stall rec_count", 832'(s_rec), 832'(exp_rec));

        // Reset during beat 10 abandons the frame and clears the counters.
        clear_q();
        send(fadd, "rstmid");
        collect(10, 50, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        exp_rec = 0;
        exp_drop = 0;
        check("rstmid out_valid", 832'(s_valid), 832'(0));
        check("rstmid rec_count", 832'(s_rec), 832'(0));
        run_record(tbl[3], "after_rst", 1'b0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].exp_drop) begin
                clear_q();
                set_rec(tbl[i]);
                bus.in_valid = 1'b1;
                step();
                check($sformatf("tbl%0d in_ready", i), 832'(s_in_ready), 832'(1));
                bus.in_valid = 1'b0;
                for (int j = 0; j < 4; j++) step();
                exp_drop++;
                check($sformatf("tbl%0d no beats", i), 832'(q_data.size()), 832'(0));
                check($sformatf("tbl%0d drop_count", i), 832'(s_drop), 832'(exp_drop));
            end else begin
                run_record(tbl[i], $sformatf("tbl%0d", i), 1'b0);
            end
        end

        // Back-to-back: second record held valid, taken on the first one's last beat.
        clear_q();
        bus.out_ready = 1'b1;
        set_rec(tbl[0]);
        bus.in_valid = 1'b1;
        s_acc = 1'b0;
        k = 0;
        while (!s_acc && k < 20) begin step(); k++; end
        set_rec(tbl[6]);
        s_acc = 1'b0;
        k = 0;
        while (!s_acc && k < 60) begin step(); k++; end
        check("b2b second accept", 832'(s_acc), 832'(1));
        bus.in_valid = 1'b0;
        collect(2 * NW, 120, 1'b0);
        check("b2b beats", 832'(q_data.size()), 832'(2 * NW));
        if (q_data.size() == 2 * NW) begin
            check("b2b no bubble", 832'(q_cyc[2*NW-1] - q_cyc[0]), 832'(2 * NW - 1));
            check("b2b frame0", q_frame(0), ref_frame(tbl[0]));
            check("b2b frame1", q_frame(NW), ref_frame(tbl[6]));
            check("b2b last1", 832'(q_lasts(NW)), 832'(26'h2000000));
        end
        exp_rec += 2;
        step();
        check("b2b rec_count", 832'(s_rec), 832'(exp_rec));

        // Random records with out_ready toggling.
        for (int r = 0; r < 200; r++) begin
            v = mk($urandom() | 32'h10, 8'($urandom_range(0, 4)),
                   {$urandom(), $urandom(), $urandom(), $urandom()},
                   {$urandom(), $urandom(), $urandom(), $urandom()},
                   {$urandom(), $urandom(), $urandom(), $urandom()}, 8'($urandom()),
                   {$urandom(), $urandom(), $urandom(), $urandom()}, 8'($urandom()),
                   1'($urandom()), $urandom(),
                   {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                   8'($urandom()), 1'b0);
            run_record(v, $sformatf("rnd%0d", r), 1'b1);
        end
        check("final drop_count", 832'(s_drop), 832'(exp_drop));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
